// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds the state encoding and the counter-width helper used by the top and its timer.
package mem_arbiter_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_CYC_DEF  = 64;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts cycles while a memory command is outstanding and flags the last allowed cycle.
// Holds at the limit instead of wrapping so a stuck enable cannot re-arm itself.
module bus_timeout_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports, one command in flight.
// Data wins arbitration unless a waiting fetch has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            if_rvalid_o,
  output logic            if_stall_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_rvalid_o,
  output logic            d_stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_rvalid_i,
  output logic            err_o
);

  localparam int SW = cnt_width(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic busy;
  logic accept;
  logic expired;
  logic resp_done;
  logic grant_d;
  logic grant_if;

  // A response is only taken after the command strobe cycle; reset masks any late answer.
  assign busy      = (state_q != ARB_IDLE);
  assign accept    = busy && !mem_req_q && !rst_i;
  assign resp_done = accept && (mem_rvalid_i || expired);

  bus_timeout_cnt #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (!busy),
    .en_i     (busy),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = 1'b0;
    grant_if    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        grant_d  = d_req_i && (!if_req_i || (streak_q < STREAK_MAX));
        grant_if = if_req_i && !grant_d;
        if (grant_d) begin
          state_d     = ARB_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          // Only grants that bypass a waiting fetch count toward starvation.
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (grant_if) begin
          state_d    = ARB_BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          streak_d   = '0;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_D: begin
        if (resp_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_rvalid_o = resp_done && (state_q == ARB_BUSY_IF);
  assign d_rvalid_o  = resp_done && (state_q == ARB_BUSY_D);

  // Timeout completions carry zero data; err_o only when the memory stayed silent.
  assign if_rdata_o = (if_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
  assign d_rdata_o  = (d_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
  assign err_o      = resp_done && !mem_rvalid_i;

  assign if_stall_o = if_req_i && !if_rvalid_o;
  assign d_stall_o  = d_req_i && !d_rvalid_o;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of whole transactions plus
// hand-written sequences for timeout, same-cycle expiry and reset mid-transaction.
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic [XLEN-1:0] if_rdata_o;
  logic            if_rvalid_o;
  logic            if_stall_o;
  logic            d_req_i;
  logic            d_we_i;
  logic [XLEN-1:0] d_addr_i;
  logic [XLEN-1:0] d_wdata_i;
  logic [XLEN-1:0] d_rdata_o;
  logic            d_rvalid_o;
  logic            d_stall_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_rvalid_i;
  logic            err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .XLEN        (XLEN),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_rvalid_o (if_rvalid_o),
    .if_stall_o  (if_stall_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_stall_o   (d_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i),
    .err_o       (err_o)
  );

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    int          lat;
    logic        early;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic ir, input logic dr, input logic we,
                              input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int lat, input logic early, input logic ed,
                              input logic [31:0] ea, input logic ewe,
                              input logic [31:0] erd);
    vec_t v;
    v.if_req = ir; v.d_req = dr; v.d_we = we;
    v.if_addr = ia; v.d_addr = da; v.d_wdata = wd; v.rdata = rd;
    v.lat = lat; v.early = early;
    v.exp_d = ed; v.exp_addr = ea; v.exp_we = ewe; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_vec(input vec_t v, input int idx);
    if_req_i = v.if_req; if_addr_i = v.if_addr;
    d_req_i = v.d_req; d_we_i = v.d_we; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk_i);
    chk($sformatf("v%0d if_stall_grant", idx), if_stall_o, v.if_req);
    chk($sformatf("v%0d d_stall_grant", idx), d_stall_o, v.d_req);
    tick();
    mem_rvalid_i = v.early;
    mem_rdata_i  = v.early ? 32'hBAD0_BAD0 : 32'h0;
    @(negedge clk_i);
    chk($sformatf("v%0d mem_req", idx), mem_req_o, 1'b1);
    chk($sformatf("v%0d mem_addr", idx), mem_addr_o, v.exp_addr);
    chk($sformatf("v%0d mem_we", idx), mem_we_o, v.exp_we);
    if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata_o, v.d_wdata);
    chk($sformatf("v%0d rvalid_in_req_cycle", idx), {if_rvalid_o, d_rvalid_o}, 2'b00);
    for (int c = 1; c < v.lat; c++) begin
      tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      @(negedge clk_i);
      chk($sformatf("v%0d wait%0d rvalid", idx, c), {if_rvalid_o, d_rvalid_o, err_o}, 3'b000);
      chk($sformatf("v%0d wait%0d mem_req", idx, c), mem_req_o, 1'b0);
    end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = v.rdata;
    @(negedge clk_i);
    chk($sformatf("v%0d if_rvalid", idx), if_rvalid_o, !v.exp_d);
    chk($sformatf("v%0d d_rvalid", idx), d_rvalid_o, v.exp_d);
    chk($sformatf("v%0d if_rdata", idx), if_rdata_o, v.exp_d ? 32'h0 : v.exp_rdata);
    chk($sformatf("v%0d d_rdata", idx), d_rdata_o, v.exp_d ? v.exp_rdata : 32'h0);
    chk($sformatf("v%0d err", idx), err_o, 1'b0);
    chk($sformatf("v%0d mem_req_resp", idx), mem_req_o, 1'b0);
    chk($sformatf("v%0d if_stall_resp", idx), if_stall_o, v.if_req && v.exp_d);
    chk($sformatf("v%0d d_stall_resp", idx), d_stall_o, v.d_req && !v.exp_d);
    $display("vec %0d: grant=%s addr=0x%08h rdata=0x%08h", idx, v.exp_d ? "D" : "IF",
             mem_addr_o, v.exp_d ? d_rdata_o : if_rdata_o);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  // Data read left unanswered for the whole window; same=1 answers on the last cycle.
  task automatic run_timeout(input logic same, input string tag);
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_5000;
    @(negedge clk_i);
    tick();
    for (int c = 1; c <= 8; c++) begin
      mem_rvalid_i = same && (c == 8);
      mem_rdata_i  = (same && (c == 8)) ? 32'hCAFE_F00D : 32'h0;
      @(negedge clk_i);
      if (c < 8) begin
        chk($sformatf("%s busy%0d pulses", tag, c), {if_rvalid_o, d_rvalid_o, err_o}, 3'b000);
      end else begin
        chk($sformatf("%s d_rvalid", tag), d_rvalid_o, 1'b1);
        chk($sformatf("%s err", tag), err_o, !same);
        chk($sformatf("%s d_rdata", tag), d_rdata_o, same ? 32'hCAFE_F00D : 32'h0);
        chk($sformatf("%s if_rvalid", tag), if_rvalid_o, 1'b0);
        $display("%s: d_rvalid=%0b err=%0b rdata=0x%08h", tag, d_rvalid_o, err_o, d_rdata_o);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    chk("reset mem_req", mem_req_o, 1'b0);
    chk("reset mem_we", mem_we_o, 1'b0);
    chk("reset mem_addr", mem_addr_o, 32'h0);
    chk("reset mem_wdata", mem_wdata_o, 32'h0);
    chk("reset err", err_o, 1'b0);
    chk("reset rvalids", {if_rvalid_o, d_rvalid_o}, 2'b00);
    tick();
    rst_i = 1'b0;
    tick();

    vecs[0] = mk(1, 0, 0, 32'h100, 0, 0, 32'hDEAD_BEEF, 3, 0, 0, 32'h100, 0, 32'hDEAD_BEEF);
    vecs[1] = mk(0, 1, 1, 0, 32'h2000_0004, 32'h55AA, 32'h0, 2, 0, 1, 32'h2000_0004, 1, 32'h0);
    vecs[2] = mk(0, 1, 0, 0, 32'h3000, 0, 32'h1234_5678, 1, 1, 1, 32'h3000, 0, 32'h1234_5678);
    begin
      string order = "DDDDIDDDDI";
      for (int k = 0; k < 10; k++) begin
        logic ed;
        logic [31:0] ia, da;
        ed = (order[k] == "D");
        ia = 32'h400 + 32'(k * 4);
        da = 32'h8000 + 32'(k * 4);
        vecs[3 + k] = mk(1, 1, 0, ia, da, 0, 32'h1000_0000 + 32'(k), 1, 0,
                         ed, ed ? da : ia, 0, 32'h1000_0000 + 32'(k));
      end
    end

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], i);
    end

    run_timeout(1'b0, "timeout");
    @(negedge clk_i);
    chk("post_timeout idle rvalid", d_rvalid_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077;
    @(negedge clk_i);
    chk("stray rvalid dropped", {if_rvalid_o, d_rvalid_o, err_o}, 3'b000);
    chk("stray rdata dropped", d_rdata_o, 32'h0);
    $display("stray mem_rvalid while idle: d_rvalid=%0b err=%0b", d_rvalid_o, err_o);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk_i);
    chk("stray no new command", mem_req_o, 1'b0);
    tick();

    run_timeout(1'b1, "same_cycle_expiry");
    tick();

    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_6000; d_wdata_i = 32'h0000_1234;
    tick();
    tick();
    rst_i = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    chk("rst_busy no pulse in reset", d_rvalid_o, 1'b0);
    tick();
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
    @(negedge clk_i);
    chk("rst_busy late rvalid", {if_rvalid_o, d_rvalid_o, err_o}, 3'b000);
    chk("rst_busy d_rdata", d_rdata_o, 32'h0);
    chk("rst_busy mem_addr", mem_addr_o, 32'h0);
    chk("rst_busy mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_busy mem_we_req", {mem_we_o, mem_req_o}, 2'b00);
    chk("rst_busy stalls", {if_stall_o, d_stall_o}, 2'b00);
    $display("reset in BUSY_D: late mem_rvalid gives d_rvalid=%0b", d_rvalid_o);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk_i);
    chk("rst_busy no command", mem_req_o, 1'b0);
    tick();

    run_vec(vecs[0], 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
